vga_fb_arbiter: RTL and testbench

//  Shares the single-port display RAM between the VGA scanner's pixel/char reads and CPU debug writes.
//  CPU writes go into a small FIFO and drain into idle RAM cycles.

---
 rtl/vga_fb_arbiter.sv | 124 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port display RAM between scanner reads and
// CPU debug writes. CPU writes are queued in a small FIFO and drained into
// cycles the scanner leaves free. A starvation guard forces one write slot
// after a long run of scanner reads while writes are pending.
`timescale 1ns/1ps
module vga_fb_arbiter #(
   parameter int AW         = 11,
   parameter int DW         = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 64
)(
   input  logic                        i_clk,
   input  logic                        i_rst,        // asynchronous, active low
   input  logic                        i_scan_req,
   input  logic [AW-1:0]               i_scan_addr,
   output logic [DW-1:0]               o_scan_data,
   output logic                        o_scan_valid,
   input  logic                        i_wr_req,
   input  logic [AW-1:0]               i_wr_addr,
   input  logic [DW-1:0]               i_wr_data,
   output logic                        o_wr_ack,
   output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
   output logic                        o_starved,
   output logic [AW-1:0]               o_ram_addr,
   output logic [DW-1:0]               o_ram_wdata,
   output logic                        o_ram_we,
   input  logic [DW-1:0]               i_ram_rdata
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_FORCE} grant_t;

   grant_t          r_state;
   grant_t          w_grant;
   logic [CW-1:0]   r_count;
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [SW-1:0]   r_starve_cnt;
   logic            r_starved;
   logic [DW-1:0]   r_scan_data;
   logic [AW-1:0]   r_fifo_addr [FIFO_DEPTH];
   logic [DW-1:0]   r_fifo_data [FIFO_DEPTH];

   logic            w_empty;
   logic            w_full;
   logic            w_push;
   logic            w_pop;

   // Full/empty come from the start-of-cycle count, so a push never feeds a
   // same-cycle write grant and a full FIFO never passes data through.
   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == CW'(FIFO_DEPTH));
   assign w_push   = i_wr_req & ~w_full;
   assign o_wr_ack = w_push;

   // Grant selection and RAM port drive for this cycle.
   always_comb begin
      w_grant     = ST_IDLE;
      w_pop       = 1'b0;
      o_ram_we    = 1'b0;
      o_ram_addr  = i_scan_addr;
      o_ram_wdata = r_fifo_data[r_rptr];
      if (!w_empty && (r_starve_cnt == SW'(STARVE_MAX - 1)))
         w_grant = ST_FORCE;
      else if (i_scan_req)
         w_grant = ST_READ;
      else if (!w_empty)
         w_grant = ST_WRITE;
      if ((w_grant == ST_WRITE) || (w_grant == ST_FORCE)) begin
         w_pop      = 1'b1;
         o_ram_we   = i_rst;
         o_ram_addr = r_fifo_addr[r_rptr];
      end
   end

   // Grant state register; a READ grant last cycle means scan_data is fresh.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_state <= ST_IDLE;
      else        r_state <= w_grant;
   end

   // FIFO pointers/count, starvation counter and sticky starved flag.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_count      <= '0;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_starve_cnt <= '0;
         r_starved    <= 1'b0;
      end else begin
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_grant == ST_READ)
            r_starve_cnt <= w_empty ? '0 : r_starve_cnt + 1'b1;
         else
            r_starve_cnt <= '0;
         if (w_grant == ST_FORCE) r_starved <= 1'b1;
      end
   end

   // FIFO storage; stale entries are harmless since reset clears the pointers.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo_addr[r_wptr] <= i_wr_addr;
         r_fifo_data[r_wptr] <= i_wr_data;
      end
   end

   // Capture RAM read data on a read grant; hold otherwise.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)                  r_scan_data <= '0;
      else if (w_grant == ST_READ) r_scan_data <= i_ram_rdata;
   end

   assign o_scan_data  = r_scan_data;
   assign o_scan_valid = (r_state == ST_READ);
   assign o_fifo_count = r_count;
   assign o_starved    = r_starved;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based model of the arbitration rules.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
   localparam int AW    = 11;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int SMAX  = 64;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b1;
   logic                      scan_req = 1'b0;
   logic [AW-1:0]             scan_addr = '0;
   logic [DW-1:0]             scan_data;
   logic                      scan_valid;
   logic                      wr_req = 1'b0;
   logic [AW-1:0]             wr_addr = '0;
   logic [DW-1:0]             wr_data = '0;
   logic                      wr_ack;
   logic [$clog2(DEPTH):0]    fifo_count;
   logic                      starved;
   logic [AW-1:0]             ram_addr;
   logic [DW-1:0]             ram_wdata;
   logic                      ram_we;
   logic [DW-1:0]             ram_rdata;

   always #5 clk = ~clk;

   vga_fb_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
      .i_clk(clk), .i_rst(rst_n),
      .i_scan_req(scan_req), .i_scan_addr(scan_addr),
      .o_scan_data(scan_data), .o_scan_valid(scan_valid),
      .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
      .o_fifo_count(fifo_count), .o_starved(starved),
      .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .o_ram_we(ram_we),
      .i_ram_rdata(ram_rdata)
   );

   // Power-on RAM contents; 0x123 holds 0x5A5A for the read/stale scenarios.
   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      if (a == 11'h123) return 16'h5A5A;
      return {5'h0, a} ^ 16'hC3A5;
   endfunction

   // Environment RAM: asynchronous read, synchronous write.
   logic [DW-1:0] ram [0:2047];
   bit            wrt [0:2047];
   always @(posedge clk) begin
      if (ram_we) begin
         ram[ram_addr] <= ram_wdata;
         wrt[ram_addr] <= 1'b1;
      end
   end
   always_comb ram_rdata = wrt[ram_addr] ? ram[ram_addr] : init_val(ram_addr);

   // Reference model state.
   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
   wr_t           q[$];
   logic [DW-1:0] mram [int];
   int            starve = 0;
   bit            m_starved = 1'b0;
   logic          m_valid = 1'b0;
   logic [DW-1:0] m_data = '0;
   int            n_chk = 0;
   int            n_fail = 0;
   logic          obs_ack, obs_we, obs_valid;
   logic [AW-1:0] obs_addr;
   logic [DW-1:0] obs_wd, obs_data;

   function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
      if (mram.exists(int'(a))) return mram[int'(a)];
      return init_val(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check the
   // combinational outputs, advance the model at the rising edge, then check
   // the registered outputs.
   task automatic step(input logic sr, input logic [AW-1:0] sa,
                       input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      bit  full, fwr, rd, wr_g;
      wr_t h;
      h = '{a: '0, d: '0};
      scan_req = sr; scan_addr = sa; wr_req = wr; wr_addr = wa; wr_data = wd;
      #1;
      full = (q.size() == DEPTH);
      fwr  = (q.size() != 0) && (starve == SMAX - 1);
      rd   = !fwr && sr;
      wr_g = fwr || (!rd && q.size() != 0);
      if (q.size() != 0) h = q[0];
      obs_ack = wr_ack; obs_we = ram_we; obs_addr = ram_addr; obs_wd = ram_wdata;
      chk("wr_ack", wr_ack, wr && !full);
      chk("ram_we", ram_we, wr_g);
      chk("ram_addr", ram_addr, wr_g ? h.a : sa);
      if (wr_g) chk("ram_wdata", ram_wdata, h.d);
      @(posedge clk);
      if (rd) begin
         m_valid = 1'b1;
         m_data  = mread(sa);
         starve  = (q.size() != 0) ? starve + 1 : 0;
      end else begin
         m_valid = 1'b0;
         starve  = 0;
      end
      if (wr_g) begin
         mram[int'(h.a)] = h.d;
         void'(q.pop_front());
         if (fwr) m_starved = 1'b1;
      end
      if (wr && !full) q.push_back('{a: wa, d: wd});
      #1;
      obs_valid = scan_valid; obs_data = scan_data;
      chk("scan_valid", scan_valid, m_valid);
      chk("scan_data", scan_data, m_data);
      chk("fifo_count", fifo_count, q.size());
      chk("starved", starved, m_starved);
      chk("count_bound", fifo_count <= DEPTH, 1);
      @(negedge clk);
   endtask

   // Pulse reset for one cycle; expects to be called just after a falling edge.
   task automatic do_reset();
      scan_req = 1'b0; wr_req = 1'b0; rst_n = 1'b0;
      #1;
      q.delete(); starve = 0; m_starved = 1'b0; m_valid = 1'b0; m_data = '0;
      chk("rst_we", ram_we, 0);
      chk("rst_valid", scan_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_starved", starved, 0);
      chk("rst_data", scan_data, 0);
      @(posedge clk); #1;
      chk("rst_we_hold", ram_we, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int            first, second, t;
      logic          hold, sr;
      logic [AW-1:0] ha;
      logic [DW-1:0] hd;
      first = 0; second = 0; t = 0; hold = 1'b0; sr = 1'b0; ha = '0; hd = '0;

      #1 rst_n = 1'b0;
      @(negedge clk);
      do_reset();

      // Idle write: acked at once, drained the following cycle.
      step(1'b0, '0, 1'b1, 11'h010, 16'hABCD);
      chk("idle_ack", obs_ack, 1);
      chk("idle_cnt1", fifo_count, 1);
      step(1'b0, '0, 1'b0, '0, '0);
      chk("idle_we", obs_we, 1);
      chk("idle_addr", obs_addr, 11'h010);
      chk("idle_wdata", obs_wd, 16'hABCD);
      chk("idle_cnt0", fifo_count, 0);

      // Read data with one cycle latency.
      step(1'b1, 11'h123, 1'b0, '0, '0);
      chk("rd_valid", obs_valid, 1);
      chk("rd_data", obs_data, 16'h5A5A);

      // Read priority, forced writes and stale read of a pending address.
      step(1'b1, 11'h123, 1'b1, 11'h123, 16'h1111);
      for (int i = 1; i <= 140; i++) begin
         step(1'b1, 11'h123, i == 1, 11'h124, 16'h2222);
         if (obs_we) begin
            if (first == 0) begin
               first = i;
            end else if (second == 0) begin
               second = i;
            end
            chk("force_no_valid", obs_valid, 0);
         end
         if (i == 10) chk("stale_data", obs_data, 16'h5A5A);
         if (i == 70) chk("new_data", obs_data, 16'h1111);
      end
      chk("first_force_cycle", first, 64);
      chk("second_force_cycle", second, 128);
      chk("starved_set", starved, 1);

      // Full FIFO: four immediate acks, fifth held until a pop frees a slot.
      for (int k = 0; k < 5; k++) begin
         t = 0;
         do begin
            step(1'b1, 11'h040, 1'b1, AW'(11'h300 + k), DW'(16'hF000 + k));
            t++;
         end while (!obs_ack && t < 200);
         chk("full_ack_timeout", obs_ack, 1);
         if (k < 4) chk("full_immediate_ack", t, 1);
         else       chk("full_fifth_waited", t > 1, 1);
      end
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, '0, '0);

      // Reset mid-drain discards queued entries.
      for (int k = 0; k < 3; k++) step(1'b1, 11'h050, 1'b1, AW'(11'h400 + k), DW'(16'h7700 + k));
      chk("pre_reset_count", fifo_count, 3);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, '0, 1'b0, '0, '0);
         chk("post_reset_no_we", obs_we, 0);
      end

      // Randomized traffic over a small address window to provoke hazards.
      for (int c = 0; c < 400; c++) begin
         if (!hold && ($urandom_range(0, 99) < 45)) begin
            hold = 1'b1;
            ha   = AW'($urandom_range(0, 15));
            hd   = DW'($urandom);
         end
         sr = (c >= 150 && c < 300) ? 1'b1 : ($urandom_range(0, 99) < 60);
         step(sr, AW'($urandom_range(0, 15)), hold, ha, hd);
         if (obs_ack) hold = 1'b0;
      end
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, '0, '0);
      chk("final_empty", fifo_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
